issue_operand_scoreboard: RTL and testbench

- Tracks in-flight physical destination registers between issue and writeback.
- Answers the issue stage's per-read-port "inuse" queries, so an instruction is held until its source operands are written back.
- Provides a quiesce handshake (drain all outstanding writes) for the global control unit: fences, interrupts, privilege changes.
- One instance for the integer file; a second instance with READ_PORTS=3, ZERO_REG_HARDWIRED=0 serves the FP file.

---
 rtl/issue_operand_scoreboard.sv | 128 ++++++++++++
 tb/tb_issue_operand_scoreboard.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/issue_operand_scoreboard.sv
// Tracks in-flight physical destination registers from issue to writeback,
// answers per-read-port inuse queries and runs the quiesce/drain handshake.

module issue_operand_scoreboard_rport #(
  parameter int NUM_PHYS_REGS      = 64,
  parameter int NUM_WB_PORTS       = 3,
  parameter int ZERO_REG_HARDWIRED = 1,
  localparam int AW = $clog2(NUM_PHYS_REGS)
) (
  input  logic [NUM_PHYS_REGS-1:0]   inuse_vec,
  input  logic [AW-1:0]              rs,
  input  logic [NUM_WB_PORTS-1:0]    clear_valid,
  input  logic [NUM_WB_PORTS*AW-1:0] clear_addr,
  output logic                       hit
);
  logic byp;

  // Same-cycle writeback bypass: a matching clear releases the operand now.
  always_comb begin
    byp = 1'b0;
    for (int k = 0; k < NUM_WB_PORTS; k++)
      if (clear_valid[k] && clear_addr[k*AW +: AW] == rs) byp = 1'b1;
    hit = inuse_vec[rs] & ~byp & ~((ZERO_REG_HARDWIRED != 0) && (rs == '0));
  end
endmodule

module issue_operand_scoreboard #(
  parameter int NUM_PHYS_REGS      = 64,
  parameter int READ_PORTS         = 2,
  parameter int NUM_WB_PORTS       = 3,
  parameter int ZERO_REG_HARDWIRED = 1,
  localparam int AW = $clog2(NUM_PHYS_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_valid,
  input  logic [AW-1:0]              set_addr,
  input  logic [NUM_WB_PORTS-1:0]    clear_valid,
  input  logic [NUM_WB_PORTS*AW-1:0] clear_addr,
  input  logic [READ_PORTS*AW-1:0]   rs_addr,
  output logic [READ_PORTS-1:0]      inuse,
  output logic [AW:0]                outstanding,
  input  logic                       quiesce_req,
  output logic                       quiesce_ack,
  output logic                       issue_block
);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [NUM_PHYS_REGS-1:0]  inuse_r, inuse_d, set_mask, clr_mask;
  logic [NUM_WB_PORTS-1:0]   clr_eff;
  logic [AW:0]               count_r, count_d, dec_cnt;
  logic                      set_eff, inc;

  always_comb begin
    set_eff  = set_valid && !((ZERO_REG_HARDWIRED != 0) && (set_addr == '0));
    set_mask = '0;
    if (set_eff) set_mask[set_addr] = 1'b1;
    inc      = set_eff && !inuse_r[set_addr];
    clr_mask = '0;
    clr_eff  = '0;
    dec_cnt  = '0;
    // A clear only counts if the bit is set, no same-cycle set wins over it,
    // and no lower-numbered port already cleared the same register.
    for (int k = 0; k < NUM_WB_PORTS; k++) begin
      if (clear_valid[k]) begin
        clr_mask[clear_addr[k*AW +: AW]] = 1'b1;
        clr_eff[k] = inuse_r[clear_addr[k*AW +: AW]] && !set_mask[clear_addr[k*AW +: AW]];
        for (int j = 0; j < k; j++)
          if (clear_valid[j] && clear_addr[j*AW +: AW] == clear_addr[k*AW +: AW])
            clr_eff[k] = 1'b0;
      end
      if (clr_eff[k]) dec_cnt = dec_cnt + (AW+1)'(1);
    end
    inuse_d = (inuse_r & ~clr_mask) | set_mask;
    count_d = count_r + {{AW{1'b0}}, inc} - dec_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inuse_r <= '0;
      count_r <= '0;
      state_q <= IDLE;
    end else begin
      inuse_r <= inuse_d;
      count_r <= count_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_block = 1'b0;
    quiesce_ack = 1'b0;
    case (state_q)
      IDLE:  if (quiesce_req) state_d = DRAIN;
      DRAIN: begin
        issue_block = 1'b1;
        if (!quiesce_req)       state_d = IDLE;
        else if (count_d == '0) state_d = DONE;
      end
      DONE: begin
        issue_block = 1'b1;
        quiesce_ack = 1'b1;
        // A late producer slipping through re-opens the drain.
        if (!quiesce_req)   state_d = IDLE;
        else if (set_valid) state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign outstanding = count_r;

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rport
    issue_operand_scoreboard_rport #(
      .NUM_PHYS_REGS      (NUM_PHYS_REGS),
      .NUM_WB_PORTS       (NUM_WB_PORTS),
      .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_rport (
      .inuse_vec   (inuse_r),
      .rs          (rs_addr[i*AW +: AW]),
      .clear_valid (clear_valid),
      .clear_addr  (clear_addr),
      .hit         (inuse[i])
    );
  end
endmodule

// File: tb/tb_issue_operand_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized set/clear traffic
// compared against a per-register bit model.

module tb_issue_operand_scoreboard;
  localparam int N  = 64;
  localparam int RP = 2;
  localparam int WB = 3;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              set_valid;
  logic [AW-1:0]     set_addr;
  logic [WB-1:0]     clear_valid;
  logic [WB*AW-1:0]  clear_addr;
  logic [RP*AW-1:0]  rs_addr;
  logic [RP-1:0]     inuse;
  logic [AW:0]       outstanding;
  logic              quiesce_req;
  logic              quiesce_ack;
  logic              issue_block;

  int total = 0;
  int bad   = 0;
  bit mdl [N];

  issue_operand_scoreboard #(
    .NUM_PHYS_REGS(N), .READ_PORTS(RP), .NUM_WB_PORTS(WB), .ZERO_REG_HARDWIRED(1)
  ) dut (
    .clk(clk), .rst(rst), .set_valid(set_valid), .set_addr(set_addr),
    .clear_valid(clear_valid), .clear_addr(clear_addr), .rs_addr(rs_addr),
    .inuse(inuse), .outstanding(outstanding), .quiesce_req(quiesce_req),
    .quiesce_ack(quiesce_ack), .issue_block(issue_block)
  );

  always #5 clk = ~clk;

  function automatic int pop();
    int c = 0;
    for (int r = 0; r < N; r++) c += int'(mdl[r]);
    return c;
  endfunction

  function automatic bit exp_inuse(int rs);
    bit v = mdl[rs];
    if (rs == 0) v = 1'b0;
    for (int k = 0; k < WB; k++)
      if (clear_valid[k] && int'(clear_addr[k*AW +: AW]) == rs) v = 1'b0;
    return v;
  endfunction

  task automatic idle_in();
    set_valid = 1'b0; set_addr = '0; clear_valid = '0; clear_addr = '0;
  endtask

  task automatic do_set(int a);
    set_valid = 1'b1; set_addr = AW'(a);
  endtask

  task automatic do_clr(int k, int a);
    clear_valid[k] = 1'b1; clear_addr[k*AW +: AW] = AW'(a);
  endtask

  // Advance one clock; the model absorbs the inputs presented this cycle.
  task automatic tick();
    if (rst) begin
      for (int r = 0; r < N; r++) mdl[r] = 1'b0;
    end else begin
      for (int k = 0; k < WB; k++)
        if (clear_valid[k]) mdl[int'(clear_addr[k*AW +: AW])] = 1'b0;
      if (set_valid && set_addr != 0) mdl[int'(set_addr)] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; quiesce_req = 1'b0; rs_addr = '0; idle_in();
    tick(); tick();
    rst = 1'b0; #1;
    total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    total++; if (issue_block !== 1'b0) begin bad++; $display("FAIL reset_block got=%b exp=0", issue_block); end
    total++; if (quiesce_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", quiesce_ack); end
    total++; if (inuse !== 2'b00) begin bad++; $display("FAIL reset_inuse got=%b exp=00", inuse); end
  endtask

  task automatic test_basic();
    do_set(5); tick(); idle_in();
    rs_addr[0 +: AW] = 6'd5; #1;
    total++; if (inuse[0] !== 1'b1) begin bad++; $display("FAIL basic_inuse got=%b exp=1", inuse[0]); end
    total++; if (outstanding !== 7'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", outstanding); end
    do_clr(1, 5); #1;
    total++; if (inuse[0] !== 1'b0) begin bad++; $display("FAIL basic_bypass got=%b exp=0", inuse[0]); end
    tick(); idle_in(); #1;
    total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL basic_cleared got=%0d exp=0", outstanding); end
  endtask

  task automatic test_zero_reg();
    do_set(0); tick(); idle_in();
    rs_addr[0 +: AW] = 6'd0; #1;
    total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL zero_count got=%0d exp=0", outstanding); end
    total++; if (inuse[0] !== 1'b0) begin bad++; $display("FAIL zero_inuse got=%b exp=0", inuse[0]); end
  endtask

  task automatic test_set_clear_same();
    do_set(9); tick(); idle_in();
    do_set(9); do_clr(0, 9); tick(); idle_in();
    rs_addr[0 +: AW] = 6'd9; #1;
    total++; if (outstanding !== 7'd1) begin bad++; $display("FAIL same_set_count got=%0d exp=1", outstanding); end
    total++; if (inuse[0] !== 1'b1) begin bad++; $display("FAIL same_set_bit got=%b exp=1", inuse[0]); end
    do_clr(2, 9); tick(); idle_in();
    do_set(9); do_clr(1, 9); tick(); idle_in(); #1;
    total++; if (outstanding !== 7'd1) begin bad++; $display("FAIL same_from0_count got=%0d exp=1", outstanding); end
    total++; if (inuse[0] !== 1'b1) begin bad++; $display("FAIL same_from0_bit got=%b exp=1", inuse[0]); end
    do_clr(0, 9); tick(); idle_in();
  endtask

  task automatic test_multi_clear();
    do_set(3); tick(); do_set(4); tick(); do_set(7); tick(); idle_in(); #1;
    total++; if (outstanding !== 7'd3) begin bad++; $display("FAIL multi_fill got=%0d exp=3", outstanding); end
    do_clr(0, 3); do_clr(1, 4); do_clr(2, 7); tick(); idle_in(); #1;
    total++; if (outstanding !== 7'd0) begin bad++; $display("FAIL multi_drain got=%0d exp=0", outstanding); end
    do_set(4); tick(); do_set(6); tick(); idle_in();
    do_clr(0, 4); do_clr(2, 4); tick(); idle_in(); #1;
    total++; if (outstanding !== 7'd1) begin bad++; $display("FAIL dup_clear got=%0d exp=1", outstanding); end
    do_clr(1, 12); tick(); idle_in(); #1;
    total++; if (outstanding !== 7'd1) begin bad++; $display("FAIL unset_clear got=%0d exp=1", outstanding); end
    do_clr(0, 6); tick(); idle_in();
  endtask

  task automatic test_quiesce();
    do_set(20); tick(); do_set(21); tick(); idle_in();
    quiesce_req = 1'b1; tick();
    total++; if (issue_block !== 1'b1) begin bad++; $display("FAIL q_block got=%b exp=1", issue_block); end
    do_clr(0, 20); tick(); idle_in();
    tick(); tick();
    total++; if (quiesce_ack !== 1'b0) begin bad++; $display("FAIL q_early_ack got=%b exp=0", quiesce_ack); end
    do_clr(1, 21); tick(); idle_in();
    total++; if (quiesce_ack !== 1'b1) begin bad++; $display("FAIL q_ack got=%b exp=1", quiesce_ack); end
    quiesce_req = 1'b0; tick();
    total++; if ({quiesce_ack, issue_block} !== 2'b00) begin bad++; $display("FAIL q_release got=%b exp=00", {quiesce_ack, issue_block}); end
    quiesce_req = 1'b1; tick();
    total++; if ({quiesce_ack, issue_block} !== 2'b01) begin bad++; $display("FAIL q_empty_drain got=%b exp=01", {quiesce_ack, issue_block}); end
    tick();
    total++; if (quiesce_ack !== 1'b1) begin bad++; $display("FAIL q_empty_ack got=%b exp=1", quiesce_ack); end
    do_set(30); tick(); idle_in();
    total++; if ({quiesce_ack, issue_block} !== 2'b01) begin bad++; $display("FAIL q_redrain got=%b exp=01", {quiesce_ack, issue_block}); end
    do_clr(2, 30); tick(); idle_in();
    total++; if (quiesce_ack !== 1'b1) begin bad++; $display("FAIL q_reack got=%b exp=1", quiesce_ack); end
    quiesce_req = 1'b0; tick();
  endtask

  task automatic test_random();
    int exp_cnt;
    for (int c = 0; c < 10000; c++) begin
      set_valid = 1'($urandom_range(0, 1));
      set_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      clear_valid = WB'($urandom);
      for (int k = 0; k < WB; k++)
        clear_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      for (int i = 0; i < RP; i++) rs_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < RP; i++) begin
        total++;
        if (inuse[i] !== exp_inuse(int'(rs_addr[i*AW +: AW]))) begin
          bad++; $display("FAIL rand_inuse cyc=%0d port=%0d got=%b exp=%b", c, i, inuse[i], exp_inuse(int'(rs_addr[i*AW +: AW])));
        end
      end
      tick();
      exp_cnt = pop();
      total++;
      if (outstanding !== 7'(exp_cnt)) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, outstanding, exp_cnt); end
    end
    idle_in();
  endtask

  task automatic test_reset_mid_drain();
    do_set(40); tick(); idle_in();
    quiesce_req = 1'b1; tick();
    rst = 1'b1; tick();
    rs_addr[0 +: AW] = 6'd40; #1;
    total++; if ({outstanding, quiesce_ack, issue_block, inuse[0]} !== 10'd0) begin
      bad++; $display("FAIL rst_mid_drain got cnt=%0d ack=%b blk=%b inuse=%b exp all 0", outstanding, quiesce_ack, issue_block, inuse[0]);
    end
    rst = 1'b0; quiesce_req = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_reg();
    test_set_clear_same();
    test_multi_clear();
    test_quiesce();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
